// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential word fetches to a 1-cycle memory
// and buffers the returned {pc, inst} pairs in a first-word fall-through FIFO.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      redirect,
   input  logic [31:0]               redirect_pc,
   output logic                      mem_req,
   output logic [31:0]               mem_addr,
   input  logic                      mem_valid,
   input  logic [31:0]               mem_rdata,
   output logic                      out_valid,
   output logic [31:0]               out_inst,
   output logic [31:0]               out_pc,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0]   DEPTH_W = DEPTH[CW:0];
   localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

   logic [31:0]   fetch_pc_r;
   logic          inflight_r;
   logic [31:0]   inflight_pc_r;
   logic [PW-1:0] rd_ptr_r;
   logic [PW-1:0] wr_ptr_r;
   logic [CW-1:0] count_r;
   logic [31:0]   pc_mem_r   [DEPTH];
   logic [31:0]   inst_mem_r [DEPTH];

   logic [CW:0]   occupancy_s;
   logic          fetch_s;
   logic          push_s;
   logic          pop_s;
   logic          head_valid_s;
   logic [31:0]   fetch_addr_s;
   logic [CW-1:0] count_nxt_s;

   // Request gating counts the outstanding fetch but never credits a same-cycle pop.
   always_comb begin
      occupancy_s  = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
      fetch_addr_s = word_align(fetch_pc_r);
      head_valid_s = (count_r != {CW{1'b0}});
      fetch_s      = rst & ~redirect & (occupancy_s < DEPTH_W);
      push_s       = rst & ~redirect & mem_valid & inflight_r;
      pop_s        = rst & ~redirect & head_valid_s & out_ready;
   end

   // Occupancy update for push, pop or both.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Fetch address, outstanding-request tracking and FIFO pointers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_r    <= word_align(RESET_PC);
         inflight_r    <= 1'b0;
         inflight_pc_r <= 32'h0000_0000;
         rd_ptr_r      <= {PW{1'b0}};
         wr_ptr_r      <= {PW{1'b0}};
         count_r       <= {CW{1'b0}};
      end else if (redirect) begin
         fetch_pc_r    <= word_align(redirect_pc);
         inflight_r    <= 1'b0;
         inflight_pc_r <= inflight_pc_r;
         rd_ptr_r      <= {PW{1'b0}};
         wr_ptr_r      <= {PW{1'b0}};
         count_r       <= {CW{1'b0}};
      end else begin
         if (fetch_s) begin
            fetch_pc_r    <= fetch_pc_r + 32'd4;
            inflight_r    <= 1'b1;
            inflight_pc_r <= fetch_addr_s;
         end else begin
            inflight_r    <= 1'b0;
         end
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r <= count_nxt_s;
      end
   end

   // Entry storage; contents are only meaningful below count, so no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         pc_mem_r[wr_ptr_r]   <= inflight_pc_r;
         inst_mem_r[wr_ptr_r] <= mem_rdata;
      end
   end

   assign mem_req   = fetch_s;
   assign mem_addr  = fetch_addr_s;
   assign out_valid = head_valid_s;
   assign out_pc    = pc_mem_r[rd_ptr_r];
   assign out_inst  = inst_mem_r[rd_ptr_r];
   assign count     = count_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a 1-cycle memory model answers requests,
// expected {pc, inst} pairs are queued by the stimulus and checked at each pop.
module tb_fetch_queue;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_ready;
   logic [2:0]  count;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_pc   [$];
   logic [31:0] exp_inst [$];
   logic [31:0] key      = 32'h0000_0000;
   logic        rdy_en   = 1'b0;
   logic        rnd_mode = 1'b0;
   logic        bound_chk = 1'b0;
   logic        spur_req = 1'b0;

   fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid),
      .mem_rdata(mem_rdata), .out_valid(out_valid), .out_inst(out_inst),
      .out_pc(out_pc), .out_ready(out_ready), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   // Memory model: capture request mid-cycle, answer in the following cycle.
   initial begin
      logic        cap_v;
      logic [31:0] cap_a;
      mem_valid = 1'b0;
      mem_rdata = 32'h0000_0000;
      forever begin
         @(negedge clk);
         cap_v = mem_req | spur_req;
         cap_a = mem_addr;
         @(posedge clk);
         #1;
         mem_valid = cap_v;
         mem_rdata = cap_a ^ key;
      end
   end

   // Monitor: compare the head against the scoreboard whenever a pop will happen.
   initial begin
      forever begin
         @(negedge clk);
         if (bound_chk) begin
            checks++;
            if (count > 3'd4) begin
               errors++;
               $display("FAIL count_bound: got %0d expected <= 4", count);
            end
         end
         if (rst && !redirect && out_valid && out_ready) begin
            if (exp_pc.size() == 0) begin
               chk("unexpected_pop", out_pc, 32'hDEAD_DEAD);
            end else begin
               chk("pop_pc", out_pc, exp_pc.pop_front());
               chk("pop_inst", out_inst, exp_inst.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      out_ready = rdy_en && (exp_pc.size() != 0) && (!rnd_mode || ($urandom_range(0, 1) == 1));
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic push_exp(input logic [31:0] start, input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = start + 32'(4 * i);
         exp_pc.push_back(a);
         exp_inst.push_back(a ^ key);
      end
   endtask

   task automatic wait_empty(input int budget);
      int n;
      n = 0;
      while (exp_pc.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      checks++;
      if (exp_pc.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d entries left expected 0", exp_pc.size());
         exp_pc.delete();
         exp_inst.delete();
      end
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      redirect    = 1'b1;
      redirect_pc = pc;
      tick();
      redirect    = 1'b0;
   endtask

   initial begin
      logic [31:0] wrap_addr [3];
      wrap_addr[0] = 32'hFFFF_FFF8;
      wrap_addr[1] = 32'hFFFF_FFFC;
      wrap_addr[2] = 32'h0000_0000;
      rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0000_0000; out_ready = 1'b0;
      repeat (3) tick();
      settle();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);

      // Free-run from reset, memory returns the address as data.
      key = 32'h0000_0000;
      push_exp(32'h0000_0000, 8);
      rdy_en = 1'b1; out_ready = 1'b1; rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         settle();
         chk("t1_mem_req", 32'(mem_req), 32'd1);
         chk("t1_mem_addr", mem_addr, 32'(4 * i));
         if (i == 1) chk("t1_fill_latency", 32'(out_valid), 32'd0);
         if (i >= 2) chk("t1_steady_count", 32'(count), 32'd1);
         tick();
      end
      wait_empty(40);

      // Fill with out_ready low, spurious mem_valid while idle, then drain.
      rdy_en = 1'b0; out_ready = 1'b0; key = 32'h1234_5678; rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         settle();
         if (i < 4) begin
            chk("t2_mem_req", 32'(mem_req), 32'd1);
            chk("t2_mem_addr", mem_addr, 32'(4 * i));
         end else begin
            chk("t2_mem_req_full", 32'(mem_req), 32'd0);
         end
         if (i == 5) spur_req = 1'b1;
         if (i == 6) spur_req = 1'b0;
         tick();
      end
      settle();
      chk("t2_count_full", 32'(count), 32'd4);
      chk("t2_head_pc", out_pc, 32'h0000_0000);
      chk("t2_head_inst", out_inst, 32'h1234_5678);
      push_exp(32'h0000_0000, 4);
      rdy_en = 1'b1; out_ready = 1'b1;
      settle();
      chk("t2_no_pop_credit", 32'(mem_req), 32'd0);
      tick();
      settle();
      chk("t2_resume_req", 32'(mem_req), 32'd1);
      chk("t2_resume_addr", mem_addr, 32'h0000_0010);
      wait_empty(40);

      // Redirect with three entries queued and one response in flight.
      rdy_en = 1'b0; out_ready = 1'b0; key = 32'hCAFE_0000;
      do_redirect(32'h0000_0200);
      repeat (4) tick();
      settle();
      chk("t3_count_before", 32'(count), 32'd3);
      chk("t3_req_blocked", 32'(mem_req), 32'd0);
      do_redirect(32'h0000_0102);
      settle();
      chk("t3_count_flushed", 32'(count), 32'd0);
      chk("t3_out_valid", 32'(out_valid), 32'd0);
      chk("t3_mem_req", 32'(mem_req), 32'd1);
      chk("t3_mem_addr", mem_addr, 32'h0000_0100);
      push_exp(32'h0000_0100, 4);
      rdy_en = 1'b1;
      tick();
      settle();
      chk("t3_valid_early", 32'(out_valid), 32'd0);
      tick();
      settle();
      chk("t3_valid_on_time", 32'(out_valid), 32'd1);
      chk("t3_first_pc", out_pc, 32'h0000_0100);
      wait_empty(40);

      // Address wrap at the top of the 32-bit space.
      rdy_en = 1'b0; out_ready = 1'b0; key = 32'h0F0F_F0F0;
      do_redirect(32'hFFFF_FFFA);
      push_exp(32'hFFFF_FFF8, 5);
      rdy_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("t4_mem_req", 32'(mem_req), 32'd1);
         chk("t4_wrap_addr", mem_addr, wrap_addr[i]);
         tick();
      end
      wait_empty(40);

      // Random back-pressure around the full point.
      rdy_en = 1'b0; out_ready = 1'b0; key = 32'h5555_AAAA;
      do_redirect(32'h0000_0400);
      push_exp(32'h0000_0400, 40);
      rnd_mode = 1'b1; bound_chk = 1'b1; rdy_en = 1'b1;
      wait_empty(400);
      rnd_mode = 1'b0; bound_chk = 1'b0;

      // Reset one cycle after a request: its response must be dropped.
      rdy_en = 1'b0; out_ready = 1'b0; key = 32'h1357_9BDF;
      do_redirect(32'h0000_0800);
      settle();
      chk("t6_req", 32'(mem_req), 32'd1);
      chk("t6_req_addr", mem_addr, 32'h0000_0800);
      tick();
      rst = 1'b0;
      settle();
      chk("t6_req_in_reset", 32'(mem_req), 32'd0);
      tick();
      rst = 1'b1;
      settle();
      chk("t6_count", 32'(count), 32'd0);
      chk("t6_out_valid", 32'(out_valid), 32'd0);
      chk("t6_mem_req", 32'(mem_req), 32'd1);
      chk("t6_mem_addr", mem_addr, 32'h0000_0000);
      tick();
      settle();
      chk("t6_count_after", 32'(count), 32'd0);
      push_exp(32'h0000_0000, 3);
      rdy_en = 1'b1;
      wait_empty(40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 redirect  input  1  branch/jump taken; flush the queue and restart fetch.
REQ-006 redirect_pc  input  32  new fetch address, valid while redirect=1.
REQ-007 mem_req  output  1  instruction-memory read request, this cycle.
REQ-008 mem_addr  output  32  word-aligned fetch address, valid while mem_req=1.
REQ-009 mem_valid  input  1  read data valid; SHALL arrive exactly 1 cycle after its mem_req.
REQ-010 mem_rdata  input  32  instruction word returned by memory.
REQ-011 out_valid  output  1  head entry available to decode.
REQ-012 out_inst  output  32  head instruction word.
REQ-013 out_pc  output  32  address of out_inst.
REQ-014 out_ready  input  1  decode accepts head this cycle.
REQ-015 count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH.

Function
REQ-016 Internal state SHALL be: fetch_pc (32), inflight flag (1), inflight_pc (32), circular FIFO of {pc, inst} with rd_ptr/wr_ptr (log2 DEPTH bits, wrap modulo DEPTH) and count.
REQ-017 mem_req SHALL be combinational = rst & ~redirect & (count + inflight < DEPTH); a same-cycle pop SHALL NOT be credited.
REQ-018 mem_addr SHALL equal {fetch_pc[31:2], 2'b00}.
REQ-019 On each cycle mem_req=1: fetch_pc <= fetch_pc + 4 (mod 2^32, wraps to 0); inflight <= 1; inflight_pc <= mem_addr. Otherwise inflight <= 0.
REQ-020 Push: when mem_valid=1, inflight=1 and redirect=0, {inflight_pc, mem_rdata} SHALL be written at wr_ptr; wr_ptr advances.
REQ-021 mem_valid while inflight=0 SHALL be ignored.
REQ-022 out_valid = (count != 0); out_inst/out_pc SHALL be the entry at rd_ptr (first-word fall-through, 0-cycle read latency).
REQ-023 Pop: when out_valid & out_ready & ~redirect, rd_ptr advances.
REQ-024 Simultaneous push and pop SHALL leave count unchanged, both pointers advancing; this SHALL be legal at count=DEPTH only if an inflight exists, which REQ-017 guarantees cannot overflow.
REQ-025 out_ready while out_valid=0 SHALL have no effect.
REQ-026 redirect=1 SHALL, at the next edge: clear count, rd_ptr, wr_ptr, inflight; set fetch_pc <= {redirect_pc[31:2], 2'b00}; discard any mem_valid data arriving in that cycle; no pop.
REQ-027 After redirect deasserts, the first mem_req SHALL occur in that same cycle with mem_addr = redirected PC; first out_valid two cycles after the redirect edge.
REQ-028 Steady state with out_ready=1 held SHALL sustain one instruction per cycle after a 2-cycle fill latency.
REQ-029 Entries SHALL leave in exactly the order requested; out_pc of consecutive pops SHALL differ by 4 absent redirect.

Reset
REQ-030 While rst=0 at an edge: fetch_pc <= RESET_PC & ~3, inflight <= 0, pointers <= 0, count <= 0; mem_req SHALL be 0 during rst=0.
REQ-031 After reset: out_valid=0, count=0; out_inst/out_pc don't-care while out_valid=0.
REQ-032 rst takes priority over redirect, mem_valid and out_ready; a response for a request issued before reset SHALL be discarded.

Verification
REQ-033 Reset, then out_ready=1, memory returns addr as data -> mem_addr 0,4,8,... on consecutive cycles; out_valid first high 2 cycles after rst release; out_pc=out_inst=0,4,8.
REQ-034 DEPTH=4, out_ready=0 -> exactly 4 requests (0..C), count=4, mem_req=0 thereafter; release out_ready -> pops 0,4,8,C in order, fetch resumes at 0x10.
REQ-035 Queue holding 3 entries with inflight, redirect=1, redirect_pc=0x0000_0102 -> next cycle count=0, out_valid=0, inflight response dropped; next mem_addr=0x0000_0100.
REQ-036 RESET_PC=32'hFFFF_FFF8, free-run -> mem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000; out_pc matches with no gap.
REQ-037 Random out_ready toggling at count=DEPTH-1 with push -> no lost or duplicated entry, count never exceeds DEPTH, pointer wrap verified against scoreboard.
REQ-038 rst=0 asserted one cycle after mem_req=1 -> mem_valid next cycle ignored; post-reset count=0 and mem_addr=RESET_PC.
